// File: rtl/cpu_oci_dct_pkg.sv
// Shared types and helpers for the CPU OCI data/control trace buffer.
package cpu_oci_dct_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DCT_WIDTH_DEF   = 30;
  localparam int COUNT_WIDTH_DEF = 4;
  localparam int ENTRY_W         = DCT_WIDTH_DEF + COUNT_WIDTH_DEF;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_oci_dct_fifo.sv
// Generic synchronous power-of-two FIFO with wrap-bit pointers and occupancy output.
module cpu_oci_dct_fifo
  import cpu_oci_dct_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
  always_comb begin
    empty   = (wr_ptr_r == rd_ptr_r);
    full    = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    level   = wr_ptr_r - rd_ptr_r;
    rd_en_s = pop && !empty;
    wr_en_s = push && (!full || rd_en_s);
    rdata   = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Storage array; contents are not reset, the top masks rdata while empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/cpu_oci_dct_trace_buffer.sv
// Per-core DCT trace sink: capture FSM, FIFO, drop counter and end-of-test drain.
module cpu_oci_dct_trace_buffer
  import cpu_oci_dct_pkg::*;
#(
  parameter int DCT_WIDTH   = DCT_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int DEPTH       = 16,
  parameter int OVF_WIDTH   = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               capture_start,
  input  logic                               dct_valid,
  input  logic [DCT_WIDTH-1:0]               dct_buffer,
  input  logic [COUNT_WIDTH-1:0]             dct_count,
  input  logic                               test_ending,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DCT_WIDTH+COUNT_WIDTH-1:0]   rd_data,
  output logic [clog2(DEPTH):0]              fill_level,
  output logic [OVF_WIDTH-1:0]               overflow_cnt,
  output logic                               capturing,
  output logic                               test_has_ended
);

  localparam int EW    = DCT_WIDTH + COUNT_WIDTH;
  localparam int LVL_W = clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic               push_req_s;
  logic               pop_s;
  logic               empty_s;
  logic               full_s;
  logic               drop_s;
  logic               ovf_clr_s;
  logic [LVL_W-1:0]   level_s;
  logic [EW-1:0]      rdata_s;
  logic [OVF_WIDTH-1:0] overflow_cnt_r;

  cpu_oci_dct_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push_req_s),
    .pop   (pop_s),
    .wdata ({dct_count, dct_buffer}),
    .rdata (rdata_s),
    .empty (empty_s),
    .full  (full_s),
    .level (level_s)
  );

  // Zero-count entries are discarded without counting as drops.
  always_comb begin
    push_req_s = (state_r == CAPTURE) && dct_valid && (dct_count != {COUNT_WIDTH{1'b0}});
    pop_s      = !empty_s && rd_ready;
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // Next-state logic; test_ending beats capture_start in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    ovf_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (test_ending) begin
          state_nxt_s = DONE;
        end else if (capture_start) begin
          state_nxt_s = CAPTURE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CAPTURE: begin
        if (test_ending) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      DRAIN: begin
        if (empty_s || ((level_s == LVL_ONE) && pop_s)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        if (capture_start) begin
          state_nxt_s = CAPTURE;
          ovf_clr_s   = 1'b1;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Saturating drop counter, cleared when a new capture is armed from DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt_r <= {OVF_WIDTH{1'b0}};
    end else if (ovf_clr_s) begin
      overflow_cnt_r <= {OVF_WIDTH{1'b0}};
    end else if (drop_s && (overflow_cnt_r != {OVF_WIDTH{1'b1}})) begin
      overflow_cnt_r <= overflow_cnt_r + {{(OVF_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      overflow_cnt_r <= overflow_cnt_r;
    end
  end

  // Outputs are decoded directly from registered state.
  always_comb begin
    rd_valid       = !empty_s;
    fill_level     = level_s;
    overflow_cnt   = overflow_cnt_r;
    capturing      = (state_r == CAPTURE);
    test_has_ended = (state_r == DONE);
    if (empty_s) begin
      rd_data = {EW{1'b0}};
    end else begin
      rd_data = rdata_s;
    end
  end

endmodule

// File: tb/tb_cpu_oci_dct_trace_buffer.sv
// Self-checking bench: vector table, directed corner sequences and randomized run vs a queue model.
module tb_cpu_oci_dct_trace_buffer;

  localparam int DW    = 30;
  localparam int CW    = 4;
  localparam int DEPTH = 16;
  localparam int OW    = 16;
  localparam int LW    = 5;
  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic capture_start = 1'b0;
  logic dct_valid = 1'b0;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;
  logic test_ending = 1'b0;
  logic rd_ready = 1'b0;
  logic rd_valid;
  logic [DW+CW-1:0] rd_data;
  logic [LW-1:0] fill_level;
  logic [OW-1:0] overflow_cnt;
  logic capturing;
  logic test_has_ended;

  int errors = 0;
  int checks = 0;

  logic [DW+CW-1:0] mq[$];
  int mstate = M_IDLE;
  int movf = 0;

  typedef struct {
    logic cap; logic v; logic [DW-1:0] b; logic [CW-1:0] c; logic te; logic rdy;
    logic [LW-1:0] lvl; logic val; logic [DW+CW-1:0] data; logic [OW-1:0] ovf;
    logic capt; logic ended;
  } vec_t;
  vec_t tbl[11];

  cpu_oci_dct_trace_buffer #(
    .DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DEPTH), .OVF_WIDTH(OW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .capture_start(capture_start),
    .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .fill_level(fill_level), .overflow_cnt(overflow_cnt),
    .capturing(capturing), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] exp_data;
    exp_data = (mq.size() > 0) ? 64'(mq[0]) : 64'd0;
    chk("m_rd_valid", rd_valid, (mq.size() > 0) ? 64'd1 : 64'd0);
    chk("m_rd_data", rd_data, exp_data);
    chk("m_fill_level", fill_level, 64'(mq.size()));
    chk("m_overflow_cnt", overflow_cnt, 64'(movf));
    chk("m_capturing", capturing, (mstate == M_CAP) ? 64'd1 : 64'd0);
    chk("m_test_has_ended", test_has_ended, (mstate == M_DONE) ? 64'd1 : 64'd0);
  endtask

  task automatic drive(input logic cap, input logic v, input logic [DW-1:0] b,
                       input logic [CW-1:0] c, input logic te, input logic rdy);
    capture_start = cap; dct_valid = v; dct_buffer = b; dct_count = c;
    test_ending = te; rd_ready = rdy;
  endtask

  // One clock: model evaluates the spec rules on the pre-edge inputs, then compare.
  task automatic step();
    bit do_pop, do_push;
    logic [DW+CW-1:0] entry;
    do_pop  = (mq.size() > 0) && rd_ready;
    do_push = (mstate == M_CAP) && dct_valid && (dct_count != 0);
    entry   = {dct_count, dct_buffer};
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back(entry);
      else if (movf < (1 << OW) - 1) movf++;
    end
    case (mstate)
      M_IDLE:  if (test_ending) mstate = M_DONE; else if (capture_start) mstate = M_CAP;
      M_CAP:   if (test_ending) mstate = M_DRAIN;
      M_DRAIN: if (mq.size() == 0) mstate = M_DONE;
      default: if (capture_start) begin mstate = M_CAP; movf = 0; end
    endcase
    #1;
    check_model();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    mq.delete(); mstate = M_IDLE; movf = 0;
    check_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int pops;
    tbl[0]  = '{1, 0, 30'h0, 4'd0, 0, 0, 5'd0, 0, 34'h0, 16'd0, 1, 0};
    tbl[1]  = '{0, 1, 30'h1, 4'd2, 0, 0, 5'd1, 1, {4'd2, 30'h1}, 16'd0, 1, 0};
    tbl[2]  = '{0, 1, 30'h2, 4'd0, 0, 0, 5'd1, 1, {4'd2, 30'h1}, 16'd0, 1, 0};
    tbl[3]  = '{0, 1, 30'h3, 4'd7, 0, 0, 5'd2, 1, {4'd2, 30'h1}, 16'd0, 1, 0};
    tbl[4]  = '{0, 0, 30'h0, 4'd0, 0, 1, 5'd1, 1, {4'd7, 30'h3}, 16'd0, 1, 0};
    tbl[5]  = '{0, 0, 30'h0, 4'd0, 0, 1, 5'd0, 0, 34'h0, 16'd0, 1, 0};
    tbl[6]  = '{0, 1, 30'h9, 4'd1, 1, 0, 5'd1, 1, {4'd1, 30'h9}, 16'd0, 0, 0};
    tbl[7]  = '{0, 1, 30'h5, 4'd1, 0, 1, 5'd0, 0, 34'h0, 16'd0, 0, 1};
    tbl[8]  = '{0, 0, 30'h0, 4'd0, 0, 0, 5'd0, 0, 34'h0, 16'd0, 0, 1};
    tbl[9]  = '{1, 0, 30'h0, 4'd0, 0, 0, 5'd0, 0, 34'h0, 16'd0, 1, 0};
    tbl[10] = '{0, 0, 30'h0, 4'd0, 1, 0, 5'd0, 0, 34'h0, 16'd0, 0, 0};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].cap, tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].te, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_level", i), fill_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].val);
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].data);
      chk($sformatf("tbl%0d_ovf", i), overflow_cnt, tbl[i].ovf);
      chk($sformatf("tbl%0d_capt", i), capturing, tbl[i].capt);
      chk($sformatf("tbl%0d_ended", i), test_has_ended, tbl[i].ended);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk("drain_min_done", test_has_ended, 64'd1);

    // Overflow: 20 pushes into a 16-deep FIFO with no reads.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 30'(i + 1), 4'd1, 1'b0, 1'b0);
      step();
    end
    chk("ovf_level", fill_level, 64'd16);
    chk("ovf_count", overflow_cnt, 64'd4);
    chk("ovf_first", rd_data, {4'd1, 30'd1});

    // Full FIFO, simultaneous push and pop.
    drive(1'b0, 1'b1, 30'h100, 4'd3, 1'b0, 1'b1);
    step();
    chk("pp_level", fill_level, 64'd16);
    chk("pp_ovf", overflow_cnt, 64'd4);
    chk("pp_head", rd_data, {4'd1, 30'd2});
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      step();
    end
    chk("pp_last", rd_data, {4'd3, 30'h100});
    chk("pp_last_level", fill_level, 64'd1);

    // Queue two more to have 3, then end the test with toggling rd_ready.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 30'(i + 32'h200), 4'd5, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 30'h3ff, 4'd6, 1'b1, 1'b0);
    step();
    chk("te_capturing", capturing, 64'd0);
    chk("te_level", fill_level, 64'd4);
    pops = 0;
    for (int i = 0; i < 12 && pops < 4; i++) begin
      drive(1'b0, 1'b1, 30'h3fe, 4'd2, 1'b0, (i % 2) == 1);
      if (rd_valid && rd_ready) pops++;
      step();
      chk($sformatf("te_ended_%0d", i), test_has_ended, (pops == 4) ? 64'd1 : 64'd0);
    end
    chk("te_all_popped", pops, 64'd4);

    // DONE -> CAPTURE clears the drop counter.
    chk("done_ovf_kept", overflow_cnt, 64'd4);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk("restart_ovf", overflow_cnt, 64'd0);
    chk("restart_capt", capturing, 64'd1);
    chk("restart_ended", test_has_ended, 64'd0);

    // Reset mid-capture with 5 entries queued.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 30'(i + 7), 4'd4, 1'b0, 1'b0);
      step();
    end
    chk("pre_rst_level", fill_level, 64'd5);
    do_reset();
    chk("rst_level", fill_level, 64'd0);
    chk("rst_valid", rd_valid, 64'd0);

    // IDLE: test_ending wins over capture_start.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("idle_te_ended", test_has_ended, 64'd1);
    chk("idle_te_capt", capturing, 64'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            30'($urandom), 4'($urandom), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
